// File: rtl/wb_stage_param_if.sv
// wb_stage_param_if: MEM/WB write-back stage bus (pipeline side = master, stage = slave)
//   master drives: ihit, dhit, flush, instr_valid, regWr, regDst, regSel,
//                  src_data, ld_size, ld_signed, ld_off, halt_in
//   slave drives:  WEN, wsel, wdat, fwd_valid, fwd_reg, fwd_data, retired, halted
interface wb_stage_param_if #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 4,
    parameter int SEL_W  = 2,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
);
    logic                    ihit;
    logic                    dhit;
    logic                    flush;
    logic                    instr_valid;
    logic                    regWr;
    logic [REG_AW-1:0]       regDst;
    logic [SEL_W-1:0]        regSel;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [1:0]              ld_size;
    logic                    ld_signed;
    logic [OFF_W-1:0]        ld_off;
    logic                    halt_in;
    logic                    WEN;
    logic [REG_AW-1:0]       wsel;
    logic [DATA_W-1:0]       wdat;
    logic                    fwd_valid;
    logic [REG_AW-1:0]       fwd_reg;
    logic [DATA_W-1:0]       fwd_data;
    logic [CNT_W-1:0]        retired;
    logic                    halted;

    modport master (
        output ihit, dhit, flush, instr_valid, regWr, regDst, regSel,
               src_data, ld_size, ld_signed, ld_off, halt_in,
        input  WEN, wsel, wdat, fwd_valid, fwd_reg, fwd_data, retired, halted
    );

    modport slave (
        input  ihit, dhit, flush, instr_valid, regWr, regDst, regSel,
               src_data, ld_size, ld_signed, ld_off, halt_in,
        output WEN, wsel, wdat, fwd_valid, fwd_reg, fwd_data, retired, halted
    );
endinterface

// File: rtl/wb_stage_param.sv
// wb_stage_param: MEM/WB pipeline register with write-back select, load extraction and retire counter
//   CLK, nRST : clock, synchronous active-low reset
//   bus       : wb_stage_param_if.slave (pipeline inputs in, register-file/forwarding/status out)
module wb_stage_param #(
    parameter int DATA_W   = 32,
    parameter int N_SRC    = 4,
    parameter int SEL_W    = 2,
    parameter int LOAD_IDX = 3,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 32,
    parameter int OFF_W    = $clog2(DATA_W / 8)
) (
    input logic          CLK,
    input logic          nRST,
    wb_stage_param_if.slave bus
);
    logic              wen_r;
    logic [REG_AW-1:0] dst_r;
    logic [SEL_W-1:0]  sel_r;
    logic [DATA_W-1:0] words_r [N_SRC];
    logic [1:0]        size_r;
    logic              signed_r;
    logic [OFF_W-1:0]  off_r;
    logic [CNT_W-1:0]  retired_r;
    logic              halted_r;
    logic              adv;
    logic [DATA_W-1:0] sel_word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] byte_ext;
    logic [DATA_W-1:0] half_ext;
    logic [DATA_W-1:0] wdat_c;

    assign adv = bus.ihit | bus.dhit;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wen_r     <= 1'b0;
            dst_r     <= '0;
            sel_r     <= '0;
            size_r    <= '0;
            signed_r  <= 1'b0;
            off_r     <= '0;
            retired_r <= '0;
            halted_r  <= 1'b0;
            for (int i = 0; i < N_SRC; i++) words_r[i] <= '0;
        end else if (bus.flush) begin
            wen_r    <= 1'b0;
            dst_r    <= '0;
            sel_r    <= '0;
            size_r   <= '0;
            signed_r <= 1'b0;
            off_r    <= '0;
            for (int i = 0; i < N_SRC; i++) words_r[i] <= '0;
        end else if (adv) begin
            wen_r    <= bus.regWr & bus.instr_valid;
            dst_r    <= bus.regDst;
            sel_r    <= bus.regSel;
            size_r   <= bus.ld_size;
            signed_r <= bus.ld_signed;
            off_r    <= bus.ld_off;
            for (int i = 0; i < N_SRC; i++) words_r[i] <= bus.src_data[i*DATA_W +: DATA_W];
            // Counter saturates at all-ones and freezes once halted.
            if (bus.instr_valid && !halted_r && ~&retired_r) retired_r <= retired_r + 1'b1;
            if (bus.halt_in && bus.instr_valid) halted_r <= 1'b1;
        end
    end

    // Selects beyond N_SRC match no word and leave sel_word at zero.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_SRC; i++) sel_word = (sel_r == SEL_W'(i)) ? words_r[i] : sel_word;
        byte_v   = sel_word[{off_r, 3'b000} +: 8];
        half_v   = sel_word[{off_r[OFF_W-1:1], 4'b0000} +: 16];
        byte_ext = {{(DATA_W-8){signed_r & byte_v[7]}}, byte_v};
        half_ext = {{(DATA_W-16){signed_r & half_v[15]}}, half_v};
        wdat_c   = (sel_r != SEL_W'(LOAD_IDX)) ? sel_word :
                   (size_r == 2'd1) ? half_ext :
                   (size_r == 2'd2) ? byte_ext : sel_word;
    end

    assign bus.WEN       = wen_r & (dst_r != '0) & ~halted_r;
    assign bus.wsel      = dst_r;
    assign bus.wdat      = wdat_c;
    assign bus.fwd_valid = bus.WEN;
    assign bus.fwd_reg   = dst_r;
    assign bus.fwd_data  = wdat_c;
    assign bus.retired   = retired_r;
    assign bus.halted    = halted_r;
endmodule

// File: tb/tb_wb_stage_param.sv
// tb_wb_stage_param: directed and randomized checks of wb_stage_param against a reference model
module tb_wb_stage_param;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic nRST2 = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    wb_stage_param_if #(.N_SRC(4), .CNT_W(32)) bus ();
    wb_stage_param_if #(.N_SRC(3), .CNT_W(4))  bus2 ();

    wb_stage_param #(.N_SRC(4), .CNT_W(32)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
    wb_stage_param #(.N_SRC(3), .CNT_W(4))  dut2 (.CLK(CLK), .nRST(nRST2), .bus(bus2));

    // reference-model state: the instruction slot currently in write-back
    logic        m_wen;
    logic [4:0]  m_dst;
    logic [1:0]  m_sel;
    logic [31:0] m_words [4];
    logic [1:0]  m_size;
    logic        m_signed;
    logic [1:0]  m_off;
    longint      m_ret;
    logic        m_halt;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ih, input logic dh, input logic fl, input logic iv, input logic wr,
                         input logic [4:0] dst, input logic [1:0] sel, input logic [1:0] sz,
                         input logic sg, input logic [1:0] off, input logic hlt);
        bus.ihit = ih; bus.dhit = dh; bus.flush = fl; bus.instr_valid = iv; bus.regWr = wr;
        bus.regDst = dst; bus.regSel = sel; bus.ld_size = sz; bus.ld_signed = sg;
        bus.ld_off = off; bus.halt_in = hlt;
    endtask

    function automatic logic [31:0] model_wdat();
        longint w, b, h;
        if (m_sel >= 4) return 32'd0;
        w = longint'(m_words[m_sel]);
        if (m_sel != 3) return m_words[m_sel];
        if (m_size == 2) begin
            b = (w >> (8 * int'(m_off))) % 256;
            if (m_signed && b >= 128) b = b + 64'hFFFF_FF00;
            return 32'(b);
        end
        if (m_size == 1) begin
            h = (w >> (16 * (int'(m_off) / 2))) % 65536;
            if (m_signed && h >= 32768) h = h + 64'hFFFF_0000;
            return 32'(h);
        end
        return m_words[m_sel];
    endfunction

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.src_data = '0;
        nRST = 0;
        tick();
        tests++; if (bus.WEN !== 1'b0) begin fails++; $display("FAIL reset_wen got %0b want 0", bus.WEN); end
        tests++; if (bus.wsel !== 5'd0) begin fails++; $display("FAIL reset_wsel got %0d want 0", bus.wsel); end
        tests++; if (bus.wdat !== 32'd0) begin fails++; $display("FAIL reset_wdat got %h want 0", bus.wdat); end
        tests++; if (bus.retired !== 32'd0) begin fails++; $display("FAIL reset_retired got %0d want 0", bus.retired); end
        tests++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %0b want 0", bus.halted); end
        nRST = 1;
    endtask

    task automatic test_basic_write();
        drive(1, 0, 0, 1, 1, 5'd8, 2'd0, 0, 0, 0, 0);
        bus.src_data = {32'h0, 32'h0, 32'h0, 32'h12345678};
        tick();
        tests++; if (bus.WEN !== 1'b1) begin fails++; $display("FAIL basic_wen got %0b want 1", bus.WEN); end
        tests++; if (bus.wsel !== 5'd8) begin fails++; $display("FAIL basic_wsel got %0d want 8", bus.wsel); end
        tests++; if (bus.wdat !== 32'h12345678) begin fails++; $display("FAIL basic_wdat got %h want 12345678", bus.wdat); end
        tests++; if (bus.retired !== 32'd1) begin fails++; $display("FAIL basic_retired got %0d want 1", bus.retired); end
        tests++; if ({bus.fwd_valid, bus.fwd_reg, bus.fwd_data} !== {1'b1, 5'd8, 32'h12345678})
            begin fails++; $display("FAIL basic_fwd got %0b/%0d/%h want 1/8/12345678", bus.fwd_valid, bus.fwd_reg, bus.fwd_data); end
    endtask

    task automatic test_load();
        bus.src_data = {32'h80FF7F01, 32'h0, 32'h0, 32'h0};
        drive(0, 1, 0, 1, 1, 5'd3, 2'd3, 2'd2, 1, 2'd3, 0);
        tick();
        tests++; if (bus.wdat !== 32'hFFFFFF80) begin fails++; $display("FAIL load_sbyte got %h want ffffff80", bus.wdat); end
        drive(0, 1, 0, 1, 1, 5'd3, 2'd3, 2'd2, 0, 2'd3, 0);
        tick();
        tests++; if (bus.wdat !== 32'h00000080) begin fails++; $display("FAIL load_ubyte got %h want 00000080", bus.wdat); end
        drive(1, 1, 0, 1, 1, 5'd3, 2'd3, 2'd1, 1, 2'd2, 0);
        tick();
        tests++; if (bus.wdat !== 32'hFFFF80FF) begin fails++; $display("FAIL load_shalf got %h want ffff80ff", bus.wdat); end
        drive(1, 0, 0, 1, 1, 5'd3, 2'd3, 2'd1, 1, 2'd1, 0);
        tick();
        tests++; if (bus.wdat !== 32'h00007F01) begin fails++; $display("FAIL load_half_off1 got %h want 00007f01", bus.wdat); end
        drive(1, 0, 0, 1, 1, 5'd3, 2'd3, 2'd3, 1, 2'd1, 0);
        tick();
        tests++; if (bus.wdat !== 32'h80FF7F01) begin fails++; $display("FAIL load_word3 got %h want 80ff7f01", bus.wdat); end
    endtask

    task automatic test_reg0();
        logic [31:0] r0;
        r0 = bus.retired;
        drive(1, 0, 0, 1, 1, 5'd0, 2'd0, 0, 0, 0, 0);
        tick();
        tests++; if (bus.WEN !== 1'b0) begin fails++; $display("FAIL reg0_wen got %0b want 0", bus.WEN); end
        tests++; if (bus.wsel !== 5'd0) begin fails++; $display("FAIL reg0_wsel got %0d want 0", bus.wsel); end
        tests++; if (bus.retired !== r0 + 1) begin fails++; $display("FAIL reg0_retired got %0d want %0d", bus.retired, r0 + 1); end
    endtask

    task automatic test_hold_flush();
        logic [31:0] r0;
        drive(1, 0, 0, 1, 1, 5'd5, 2'd0, 0, 0, 0, 0);
        bus.src_data = {96'h0, 32'hCAFEF00D};
        tick();
        r0 = bus.retired;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1, 5'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 0);
            bus.src_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            tests++; if ({bus.WEN, bus.wsel, bus.wdat, bus.retired} !== {1'b1, 5'd5, 32'hCAFEF00D, r0})
                begin fails++; $display("FAIL hold_%0d got %0b/%0d/%h/%0d want 1/5/cafef00d/%0d", i, bus.WEN, bus.wsel, bus.wdat, bus.retired, r0); end
        end
        drive(1, 0, 1, 1, 1, 5'd7, 2'd0, 0, 0, 0, 0);
        tick();
        tests++; if ({bus.WEN, bus.wsel, bus.wdat} !== 38'd0)
            begin fails++; $display("FAIL flush_out got %0b/%0d/%h want 0/0/0", bus.WEN, bus.wsel, bus.wdat); end
        tests++; if (bus.retired !== r0) begin fails++; $display("FAIL flush_retired got %0d want %0d", bus.retired, r0); end
    endtask

    task automatic test_range_sat();
        bus2.ihit = 0; bus2.dhit = 0; bus2.flush = 0; bus2.instr_valid = 0; bus2.regWr = 0;
        bus2.regDst = 0; bus2.regSel = 0; bus2.ld_size = 0; bus2.ld_signed = 0; bus2.ld_off = 0;
        bus2.halt_in = 0; bus2.src_data = {32'hAAAA5555, 32'h11112222, 32'h33334444};
        nRST2 = 0;
        tick();
        nRST2 = 1;
        bus2.ihit = 1; bus2.instr_valid = 1; bus2.regWr = 1; bus2.regDst = 5'd4; bus2.regSel = 2'd3;
        tick();
        tests++; if (bus2.wdat !== 32'd0) begin fails++; $display("FAIL range_sel3 got %h want 0", bus2.wdat); end
        bus2.regSel = 2'd2;
        tick();
        tests++; if (bus2.wdat !== 32'hAAAA5555) begin fails++; $display("FAIL range_sel2 got %h want aaaa5555", bus2.wdat); end
        for (int i = 0; i < 14; i++) tick();
        tests++; if (bus2.retired !== 4'hF) begin fails++; $display("FAIL sat_16 got %0d want 15", bus2.retired); end
        for (int i = 0; i < 4; i++) tick();
        tests++; if (bus2.retired !== 4'hF) begin fails++; $display("FAIL sat_20 got %0d want 15", bus2.retired); end
        bus2.ihit = 0;
    endtask

    task automatic test_halt();
        logic [31:0] r0;
        r0 = bus.retired;
        drive(1, 0, 0, 1, 1, 5'd9, 2'd0, 0, 0, 0, 1);
        bus.src_data = {96'h0, 32'h55AA55AA};
        tick();
        tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL halt_set got %0b want 1", bus.halted); end
        tests++; if (bus.WEN !== 1'b0) begin fails++; $display("FAIL halt_wen got %0b want 0", bus.WEN); end
        tests++; if (bus.retired !== r0 + 1) begin fails++; $display("FAIL halt_retired got %0d want %0d", bus.retired, r0 + 1); end
        drive(1, 0, 0, 1, 1, 5'd12, 2'd0, 0, 0, 0, 0);
        tick();
        tick();
        tests++; if ({bus.WEN, bus.wsel, bus.retired} !== {1'b0, 5'd12, r0 + 1})
            begin fails++; $display("FAIL halt_frozen got %0b/%0d/%0d want 0/12/%0d", bus.WEN, bus.wsel, bus.retired, r0 + 1); end
        nRST = 0;
        tick();
        nRST = 1;
        tests++; if ({bus.halted, bus.retired} !== 33'd0)
            begin fails++; $display("FAIL halt_reset got %0b/%0d want 0/0", bus.halted, bus.retired); end
    endtask

    task automatic test_random();
        logic [127:0] src;
        logic rst_n, fl, adv, iv;
        nRST = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        m_wen = 0; m_dst = 0; m_sel = 0; m_size = 0; m_signed = 0; m_off = 0; m_ret = 0; m_halt = 0;
        for (int k = 0; k < 4; k++) m_words[k] = 0;
        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            fl    = ($urandom_range(0, 7) == 0);
            iv    = ($urandom_range(0, 3) != 0);
            src   = {$urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom), 1'($urandom), fl, iv, 1'($urandom),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 2'($urandom), 2'($urandom),
                  1'($urandom), 2'($urandom), ($urandom_range(0, 59) == 0));
            bus.src_data = src;
            nRST = rst_n;
            adv = bus.ihit | bus.dhit;
            if (!rst_n || fl) begin
                m_wen = 0; m_dst = 0; m_sel = 0; m_size = 0; m_signed = 0; m_off = 0;
                for (int k = 0; k < 4; k++) m_words[k] = 0;
                if (!rst_n) begin m_ret = 0; m_halt = 0; end
            end else if (adv) begin
                m_wen = bus.regWr && iv; m_dst = bus.regDst; m_sel = bus.regSel;
                m_size = bus.ld_size; m_signed = bus.ld_signed; m_off = bus.ld_off;
                for (int k = 0; k < 4; k++) m_words[k] = src[32*k +: 32];
                if (iv && !m_halt && m_ret < 64'hFFFF_FFFF) m_ret = m_ret + 1;
                if (iv && bus.halt_in) m_halt = 1;
            end
            tick();
            tests++; if (bus.WEN !== (m_wen && m_dst != 0 && !m_halt))
                begin fails++; $display("FAIL rnd_wen[%0d] got %0b want %0b", n, bus.WEN, m_wen && m_dst != 0 && !m_halt); end
            tests++; if (bus.wsel !== m_dst) begin fails++; $display("FAIL rnd_wsel[%0d] got %0d want %0d", n, bus.wsel, m_dst); end
            tests++; if (bus.wdat !== model_wdat()) begin fails++; $display("FAIL rnd_wdat[%0d] got %h want %h", n, bus.wdat, model_wdat()); end
            tests++; if (bus.retired !== 32'(m_ret)) begin fails++; $display("FAIL rnd_retired[%0d] got %0d want %0d", n, bus.retired, m_ret); end
            tests++; if (bus.halted !== m_halt) begin fails++; $display("FAIL rnd_halted[%0d] got %0b want %0b", n, bus.halted, m_halt); end
        end
        nRST = 1;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_load();
        test_reg0();
        test_hold_flush();
        test_range_sat();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
